vram_arbiter: RTL

Shares the single-port 32K x 16 video RAM between the text-mode pixel generator and the CPU bus. While video is active, the pixel generator owns the TEXT_FETCH and GLYPH_FETCH phases of each 4-cycle pixel period. The CPU is granted the SET_FOREGROUND and DRAW phases. During blanking the CPU may use every cycle.

---
 rtl/vram_pkg.sv | 24 ++
 rtl/vram_arbiter_if.sv | 22 ++
 rtl/vram_wbuf_fifo.sv | 52 +++++
 rtl/vram_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants, FSM encoding and slot helper for the VRAM arbiter.
package vram_pkg;

    localparam int unsigned DEF_ADDR_W     = 15;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_WBUF_DEPTH = 2;

    localparam logic [1:0] PH_TEXT_FETCH  = 2'd0;
    localparam logic [1:0] PH_GLYPH_FETCH = 2'd1;
    localparam logic [1:0] PH_SET_FG      = 2'd2;
    localparam logic [1:0] PH_DRAW        = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } arb_state_t;

    // Pixel generator owns the two fetch phases of every visible pixel period.
    function automatic logic is_pg_slot(input logic video_active, input logic [1:0] pixel_state);
        return video_active && ((pixel_state == PH_TEXT_FETCH) || (pixel_state == PH_GLYPH_FETCH));
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU request/acknowledge bus into the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = vram_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = vram_pkg::DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/vram_wbuf_fifo.sv
// Small synchronous FIFO holding posted CPU writes (address and data packed).
module vram_wbuf_fifo #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    assign head_c    = slots[rd_ptr];

    // Flags are registered from the next occupancy so consumers see clean state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == CNT_W'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) slots[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slices the single-port VRAM between the text pixel generator and the CPU.
// Optional posted-write buffer enabled with macro VRAM_WBUF_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
`ifdef VRAM_WBUF_EN
    ,
    parameter int unsigned WBUF_DEPTH = DEF_WBUF_DEPTH
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pixel_state,
    input  logic              video_active,
    input  logic [ADDR_W-1:0] pg_addr,
    output logic [DATA_W-1:0] pg_data,
    vram_arbiter_if.slave     cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              pg_slot;
    logic              cpu_slot;
    logic              rdata_load;
    logic [DATA_W-1:0] pg_hold;

    assign pg_slot  = is_pg_slot(video_active, pixel_state);
    assign cpu_slot = !pg_slot;

    // Live fetch data during the fetch-return phases, held glyph word otherwise.
    assign pg_data = (video_active && ((pixel_state == PH_GLYPH_FETCH) || (pixel_state == PH_SET_FG)))
                     ? mem_rdata : pg_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            pg_hold <= '0;
        end else if (pixel_state == PH_SET_FG) begin
            pg_hold <= mem_rdata;
        end
    end

`ifdef VRAM_WBUF_EN
    logic                     wbuf_push;
    logic                     wbuf_pop;
    logic                     wbuf_full;
    logic                     wbuf_empty;
    logic [ADDR_W+DATA_W-1:0] wbuf_head;

    vram_wbuf_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk    (clk),
        .reset  (reset),
        .push   (wbuf_push),
        .wdata  ({cpu.cpu_addr, cpu.cpu_wdata}),
        .pop    (wbuf_pop),
        .head_c (wbuf_head),
        .full   (wbuf_full),
        .empty  (wbuf_empty)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cpu.cpu_ack   <= 1'b0;
            cpu.cpu_rdata <= '0;
        end else begin
            state       <= state_nxt;
            cpu.cpu_ack <= (state_nxt == ST_ACK);
            if (rdata_load) cpu.cpu_rdata <= mem_rdata;
        end
    end

    // Idle CPU slots present cpu_addr as a harmless read; PG slots always show pg_addr.
    always_comb begin
        state_nxt  = state;
        mem_addr   = pg_slot ? pg_addr : cpu.cpu_addr;
        mem_we     = 1'b0;
        mem_wdata  = cpu.cpu_wdata;
        rdata_load = 1'b0;
`ifdef VRAM_WBUF_EN
        wbuf_push  = 1'b0;
        wbuf_pop   = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (cpu.cpu_req) begin
                    if (cpu.cpu_we) begin
`ifdef VRAM_WBUF_EN
                        if (!wbuf_full) begin
                            wbuf_push = 1'b1;
                            state_nxt = ST_ACK;
                        end
`else
                        if (cpu_slot) begin
                            mem_we    = 1'b1;
                            state_nxt = ST_ACK;
                        end
`endif
`ifdef VRAM_WBUF_EN
                    end else if (cpu_slot && wbuf_empty) begin
`else
                    end else if (cpu_slot) begin
`endif
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                rdata_load = 1'b1;
                state_nxt  = ST_ACK;
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
`ifdef VRAM_WBUF_EN
        // Reads only issue with the buffer empty, so a drain never collides with one.
        if (cpu_slot && !wbuf_empty) begin
            mem_addr  = wbuf_head[DATA_W +: ADDR_W];
            mem_wdata = wbuf_head[DATA_W-1:0];
            mem_we    = 1'b1;
            wbuf_pop  = 1'b1;
        end
`endif
    end

endmodule
